// File: rtl/rat_alu_pkg.sv
// Shared opcode and FSM types for the registered RAT ALU.
package rat_alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_ADDC = 5'd1,
        OP_SUB  = 5'd2,
        OP_SUBC = 5'd3,
        OP_CMP  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_EXOR = 5'd7,
        OP_TEST = 5'd8,
        OP_LSL  = 5'd9,
        OP_LSR  = 5'd10,
        OP_ROL  = 5'd11,
        OP_ROR  = 5'd12,
        OP_ASR  = 5'd13,
        OP_MOV  = 5'd14,
        OP_NOP  = 5'd15,
        OP_MUL  = 5'd16
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

    localparam logic [4:0] MUL_OPCODE = OP_MUL;

endpackage

// File: rtl/rat_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
module rat_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    // product is the accumulator including the step taken at this edge,
    // so the owner can register it on the same edge that done is high
    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy && (cnt_q == CW'(WIDTH - 1));
    assign product = acc_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            busy     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start && !busy) begin
            busy     <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (busy) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/rat_alu_seq.sv
// Registered RAT ALU: single-cycle ops, optional iterative MUL, C/Z flags with interrupt shadow.
module rat_alu_seq
    import rat_alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [4:0]       SEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             FLG_LD,
    input  logic             FLG_SAVE,
    input  logic             FLG_RESTORE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             VALID,
    output logic             BUSY,
    output logic             C,
    output logic             Z
);
    alu_state_t         state_q, state_d;
    logic [WIDTH:0]     alu_res;
    logic               alu_wr;
    logic               is_mul, fire_single, mul_fin;
    logic               ld_q, sc_q, sz_q;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul = MUL_EN && (SEL == MUL_OPCODE);
    assign BUSY   = (state_q == MUL);

    // alu_res[WIDTH] is the carry/borrow; alu_wr is low for ops that never touch flags
    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b1;
        case (SEL)
            OP_ADD:          alu_res = {1'b0, A} + {1'b0, B};
            OP_ADDC:         alu_res = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C};
            OP_SUB, OP_CMP:  alu_res = {1'b0, A} - {1'b0, B};
            OP_SUBC:         alu_res = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, C};
            OP_AND, OP_TEST: alu_res = {1'b0, A & B};
            OP_OR:           alu_res = {1'b0, A | B};
            OP_EXOR:         alu_res = {1'b0, A ^ B};
            OP_LSL:          alu_res = {A, C};
            OP_LSR:          alu_res = {A[0], C, A[WIDTH-1:1]};
            OP_ROL:          alu_res = {A, A[WIDTH-1]};
            OP_ROR:          alu_res = {A[0], A[0], A[WIDTH-1:1]};
            OP_ASR:          alu_res = {A[0], A[WIDTH-1], A[WIDTH-1:1]};
            OP_MOV: begin
                alu_res = {1'b0, B};
                alu_wr  = 1'b0;
            end
            default:         alu_wr  = 1'b0;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            rat_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .start   (START && (state_q == IDLE) && is_mul),
                .a       (A),
                .b       (B),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_prod)
            );
        end else begin : g_nomul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        fire_single = 1'b0;
        mul_fin     = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                if (is_mul) state_d = MUL;
                else        fire_single = 1'b1;
            end
            MUL: if (mul_done || !mul_busy) begin
                state_d = IDLE;
                mul_fin = mul_done;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            RESULT    <= '0;
            RESULT_HI <= '0;
            VALID     <= 1'b0;
            ld_q      <= 1'b0;
            C         <= 1'b0;
            Z         <= 1'b0;
            sc_q      <= 1'b0;
            sz_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            VALID   <= fire_single || mul_fin;
            if (fire_single) begin
                RESULT    <= alu_res[WIDTH-1:0];
                RESULT_HI <= '0;
            end else if (mul_fin) begin
                RESULT    <= mul_prod[WIDTH-1:0];
                RESULT_HI <= mul_prod[2*WIDTH-1:WIDTH];
            end
            if (state_q == IDLE && START && is_mul) ld_q <= FLG_LD;
            // restore wins; save below always sees the pre-update flags
            if (FLG_RESTORE) begin
                C <= sc_q;
                Z <= sz_q;
            end else if (fire_single && FLG_LD && alu_wr) begin
                C <= alu_res[WIDTH];
                Z <= (alu_res[WIDTH-1:0] == '0);
            end else if (mul_fin && ld_q) begin
                C <= |mul_prod[2*WIDTH-1:WIDTH];
                Z <= (mul_prod == '0);
            end
            if (FLG_SAVE) begin
                sc_q <= C;
                sz_q <= Z;
            end
        end
    end

endmodule

// File: tb/tb_rat_alu_seq.sv
// Randomized bench for rat_alu_seq (8-bit with MUL, 16-bit without) against an arithmetic model.
module tb_rat_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, flg_ld, flg_save, flg_restore;
    logic [4:0]  sel;
    logic [7:0]  a, b, result, result_hi;
    logic        valid, busy, c, z;

    logic        start_w, flg_ld_w, flg_save_w, flg_restore_w;
    logic [4:0]  sel_w;
    logic [15:0] a_w, b_w, result_w, result_hi_w;
    logic        valid_w, busy_w, c_w, z_w;

    rat_alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .SEL(sel), .A(a), .B(b),
        .FLG_LD(flg_ld), .FLG_SAVE(flg_save), .FLG_RESTORE(flg_restore),
        .RESULT(result), .RESULT_HI(result_hi), .VALID(valid), .BUSY(busy), .C(c), .Z(z)
    );

    rat_alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut_w (
        .CLK(clk), .RST_N(rst_n), .START(start_w), .SEL(sel_w), .A(a_w), .B(b_w),
        .FLG_LD(flg_ld_w), .FLG_SAVE(flg_save_w), .FLG_RESTORE(flg_restore_w),
        .RESULT(result_w), .RESULT_HI(result_hi_w), .VALID(valid_w), .BUSY(busy_w), .C(c_w), .Z(z_w)
    );

    int checks = 0;
    int errors = 0;

    // model flags and shadow, index 0 = 8-bit dut, 1 = 16-bit dut
    bit mc[2], mz[2], msc[2], msz[2];

    logic [15:0] o_res, o_hi;
    logic        o_vld, o_bsy, o_c, o_z;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic ref_op(input int w, input bit mul_en, input int op, input longint av, input longint bv,
                          input bit cin, output longint res, output longint hi,
                          output bit co, output bit zo, output bit wr);
        longint m    = longint'(1) << w;
        longint half = m / 2;
        longint s, p;
        res = 0; hi = 0; co = 0; wr = 1;
        case (op)
            0, 1: begin
                s   = av + bv + ((op == 1 && cin) ? 1 : 0);
                res = s % m;
                co  = (s >= m);
            end
            2, 3, 4: begin
                s   = bv + ((op == 3 && cin) ? 1 : 0);
                co  = (av < s);
                res = (av - s + m) % m;
            end
            5, 8: res = av & bv;
            6:    res = av | bv;
            7:    res = av ^ bv;
            9:  begin res = (av * 2 + (cin ? 1 : 0)) % m;     co = (av >= half);  end
            10: begin res = av / 2 + (cin ? half : 0);        co = (av % 2 == 1); end
            11: begin res = (av * 2) % m + (av >= half ? 1 : 0); co = (av >= half); end
            12: begin res = av / 2 + (av % 2) * half;         co = (av % 2 == 1); end
            13: begin res = av / 2 + (av >= half ? half : 0); co = (av % 2 == 1); end
            14: begin res = bv; wr = 0; end
            16: begin
                if (mul_en) begin
                    p   = av * bv;
                    res = p % m;
                    hi  = p / m;
                    co  = (hi != 0);
                end else begin
                    wr = 0;
                end
            end
            default: wr = 0;
        endcase
        zo = (res == 0 && hi == 0);
    endtask

    task automatic drive(input int d, input bit go, input int op, input longint av, input longint bv,
                         input bit ld, input bit sv, input bit rs);
        if (d == 0) begin
            start = go; sel = 5'(op); a = 8'(av); b = 8'(bv);
            flg_ld = ld; flg_save = sv; flg_restore = rs;
        end else begin
            start_w = go; sel_w = 5'(op); a_w = 16'(av); b_w = 16'(bv);
            flg_ld_w = ld; flg_save_w = sv; flg_restore_w = rs;
        end
    endtask

    task automatic sample(input int d);
        if (d == 0) begin
            o_res = {8'h00, result}; o_hi = {8'h00, result_hi};
            o_vld = valid; o_bsy = busy; o_c = c; o_z = z;
        end else begin
            o_res = result_w; o_hi = result_hi_w;
            o_vld = valid_w; o_bsy = busy_w; o_c = c_w; o_z = z_w;
        end
    endtask

    // Called at a negedge; issues one op (or a flag-only cycle when go=0) and checks it.
    task automatic do_op(input int d, input bit go, input int op, input longint av, input longint bv,
                         input bit ld, input bit sv, input bit rs);
        int     w      = (d == 0) ? 8 : 16;
        bit     me     = (d == 0);
        bit     is_mul = go && me && (op == 16);
        longint er, eh;
        bit     ec, ez, wr, pc, pz;
        int     lat;
        av = av & ((longint'(1) << w) - 1);
        bv = bv & ((longint'(1) << w) - 1);
        ref_op(w, me, op, av, bv, mc[d], er, eh, ec, ez, wr);
        drive(d, go, op, av, bv, ld, sv, rs);
        @(posedge clk);
        pc = mc[d]; pz = mz[d];
        if (rs) begin
            mc[d] = msc[d]; mz[d] = msz[d];
        end else if (go && !is_mul && wr && ld) begin
            mc[d] = ec; mz[d] = ez;
        end
        if (sv) begin
            msc[d] = pc; msz[d] = pz;
        end
        @(negedge clk);
        drive(d, 0, 0, 0, 0, 0, 0, 0);
        sample(d);
        if (!go) begin
            check("idle_vld", o_vld, 0);
            check("idle_c", o_c, mc[d]);
            check("idle_z", o_z, mz[d]);
            return;
        end
        lat = 1;
        if (is_mul) begin
            check("mul_busy", o_bsy, 1);
            check("mul_early_vld", o_vld, 0);
            while (!o_vld && lat < 40) begin
                if (lat == 3) drive(0, 1, int'($urandom_range(31)), $urandom, $urandom, 1'b1, 1'b0, 1'b0);
                @(posedge clk);
                @(negedge clk);
                drive(d, 0, 0, 0, 0, 0, 0, 0);
                lat++;
                sample(d);
            end
            check("mul_lat", lat, 9);
            if (ld) begin
                mc[d] = ec; mz[d] = ez;
            end
        end
        check("vld", o_vld, 1);
        check("busy_done", o_bsy, 0);
        check("res", o_res, er);
        check("res_hi", o_hi, eh);
        check("c", o_c, mc[d]);
        check("z", o_z, mz[d]);
        if (is_mul) begin
            @(posedge clk);
            @(negedge clk);
            sample(d);
            check("no_extra_vld", o_vld, 0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; mz[i] = 0; msc[i] = 0; msz[i] = 0;
        end
    endtask

    initial begin
        int d, op, nv;
        bit go;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample(0);
        check("rst_res", o_res, 0);
        check("rst_hi", o_hi, 0);
        check("rst_vld", o_vld, 0);
        check("rst_busy", o_bsy, 0);
        check("rst_c", o_c, 0);
        check("rst_z", o_z, 0);
        sample(1);
        check("rst_w_vld", o_vld, 0);
        check("rst_w_c", o_c, 0);
        rst_n = 1'b1;

        do_op(0, 1, 0, 'hF0, 'h20, 1, 0, 0);   // ADD -> 10, C=1
        do_op(0, 1, 1, 'h01, 'h01, 1, 0, 0);   // ADDC uses C -> 03
        do_op(0, 1, 2, 'h05, 'h05, 1, 0, 0);   // SUB -> 0, Z=1
        do_op(0, 1, 16, 'hFF, 'hFF, 1, 0, 0);  // MUL -> FE01
        do_op(0, 1, 0, 'hFF, 'h02, 1, 0, 0);   // C=1, Z=0
        do_op(0, 0, 0, 0, 0, 0, 1, 0);         // save shadow
        do_op(0, 1, 4, 'h33, 'h33, 1, 0, 0);   // CMP -> Z=1, C=0
        do_op(0, 1, 0, 'h01, 'h01, 1, 0, 1);   // restore beats ADD
        do_op(0, 1, 2, 'h10, 'h20, 1, 1, 0);   // save coincides with completion
        do_op(0, 1, 14, 'h00, 'h00, 1, 0, 1);  // MOV, restore pre-SUB flags

        for (int i = 0; i < 300; i++) begin
            d  = ($urandom_range(3) == 0) ? 1 : 0;
            op = ($urandom_range(5) == 0) ? 16 : int'($urandom_range(31));
            go = ($urandom_range(9) != 0);
            do_op(d, go, op, $urandom, $urandom, 1'($urandom_range(1)),
                  ($urandom_range(7) == 0), ($urandom_range(7) == 0));
        end

        do_op(1, 1, 0, 'hFFFF, 'h0001, 1, 0, 0);  // C=1
        do_op(1, 1, 10, 'h8001, 'h0000, 1, 0, 0); // LSR -> C000, C=1
        do_op(1, 1, 16, 'h0005, 'h0007, 1, 0, 0); // MUL disabled -> NOP

        // reset in the middle of a multiply
        do_op(0, 1, 0, 'hFF, 'h01, 1, 0, 0);
        drive(0, 1, 16, 'h0F, 'h0F, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        sample(0);
        check("mrst_busy", o_bsy, 0);
        check("mrst_vld", o_vld, 0);
        check("mrst_res", o_res, 0);
        check("mrst_c", o_c, 0);
        check("mrst_z", o_z, 0);
        rst_n = 1'b1;
        nv = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) nv++;
        end
        check("mrst_no_vld", nv, 0);
        do_op(0, 1, 0, 'h01, 'h01, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rat_alu_seq.md
Name: rat_alu_seq

Overview:
- Parametrised, registered successor to the RAT single-cycle ALU.
- Width is generic, and the block owns the C/Z flag register and its interrupt shadow copy.
- Adds an iterative unsigned multiply with a START/BUSY/VALID handshake.
- Sits between the register file and the writeback mux. The control unit issues START and waits for VALID.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 4..32.
- MUL_EN, 1: 1 enables the MUL opcode. With 0, MUL behaves as NOP and the multiplier logic is not built.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous, active-low reset.
- START  in  1  op request; sampled only when BUSY=0.
- SEL  in  5  opcode; see Behaviour.
- A  in  WIDTH  operand A / destination register value.
- B  in  WIDTH  operand B / immediate.
- FLG_LD  in  1  sampled with START; 1 = write C/Z when the op completes.
- FLG_SAVE  in  1  copy C/Z into the shadow register (interrupt entry).
- FLG_RESTORE  in  1  copy shadow into C/Z (RETIE).
- RESULT  out  WIDTH  registered result; low half for MUL.
- RESULT_HI  out  WIDTH  high half of the MUL product; 0 for all other ops.
- VALID  out  1  one-cycle pulse; RESULT/RESULT_HI are valid this cycle.
- BUSY  out  1  multiply in progress.
- C  out  1  carry flag register.
- Z  out  1  zero flag register.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - RESULT=0, RESULT_HI=0, VALID=0, BUSY=0, C=0, Z=0, shadow C/Z=0, FSM=IDLE.
  - Reset mid-multiply abandons the op. No VALID is produced and flags are unchanged from reset values.
- Opcodes 0-14 (single-cycle ops):
  - Codes: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 CMP, 5 AND, 6 OR, 7 EXOR, 8 TEST, 9 LSL, 10 LSR, 11 ROL, 12 ROR, 13 ASR, 14 MOV.
  - Semantics are the existing RAT ALU semantics generalised to WIDTH.
  - The internal result is WIDTH+1 bits. The MSB is the carry/borrow; borrow=1 when A < B (+cin).
  - Carry-in for ADDC, SUBC, LSL and LSR is the C register value in the START cycle, not a port.
- Opcode 16 MUL:
  - Unsigned A×B; product is 2·WIDTH bits.
  - Z = (product == 0).
  - C = (RESULT_HI != 0).
- Opcodes 15 and 17-31: NOP.
  - VALID still pulses, RESULT=0, flags unchanged regardless of FLG_LD.
- Result writeback: CMP and TEST write flags only; RESULT is still driven with the computed value.
- MOV: flags are never written, even if FLG_LD=1.
- FSM states: IDLE, MUL.
  - IDLE, START=1, single-cycle op: RESULT registered at this edge; VALID=1 for the next cycle only. Latency 1; throughput 1 op/cycle.
  - IDLE, START=1, SEL=MUL, MUL_EN=1: latch A, B and FLG_LD; zero the accumulator; BUSY=1; go to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles, counter 0..WIDTH-1.
    - On the last step: write RESULT/RESULT_HI, VALID=1, BUSY=0, go to IDLE.
    - Total latency is WIDTH+1 cycles from the START edge to the VALID cycle (9 for WIDTH=8).
  - START while BUSY=1 is ignored. It is not queued.
- Flag update: C/Z are written in the VALID cycle's edge, and only if FLG_LD was captured as 1 at START.
- Flag conflict priority (same edge):
  - FLG_RESTORE beats an op completion and FLG_SAVE.
  - FLG_SAVE captures the pre-update C/Z when it coincides with a completion.
- Inputs A, B and SEL may change freely while BUSY=1.

Decomposition:
- Package rat_alu_pkg holds:
  - typedef enum logic [4:0] alu_op_t (ADD..MOV, NOP=15, MUL=16).
  - typedef enum logic alu_state_t {IDLE, MUL}.
  - Localparam MUL_OPCODE.
- One sub-module, rat_mul_iter (WIDTH): start, A, B in; busy, done, product[2·WIDTH-1:0] out; same clock and reset.
- The combinational op decode stays in the top level.

Test Plan:
- Reset then ADD: RST_N=0 for 2 cycles; START, SEL=0, A=8'hF0, B=8'h20, FLG_LD=1 → next cycle VALID=1, RESULT=8'h10, C=1, Z=0.
- ADDC consumes the registered carry: immediately after the previous test, SEL=1, A=8'h01, B=8'h01 → RESULT=8'h03, C=0; then SUB A=8'h05, B=8'h05 → RESULT=0, Z=1, C=0.
- MUL, WIDTH=8: START, SEL=16, A=8'hFF, B=8'hFF, FLG_LD=1 → BUSY high for 8 cycles; VALID on cycle 9 with RESULT_HI=8'hFE, RESULT=8'h01, C=1, Z=0. A START pulse mid-busy produces no extra VALID.
- Flag shadow: C=1, Z=0, then FLG_SAVE; CMP A=B=8'h33 gives Z=1, C=0; then FLG_RESTORE in the same cycle as a completing ADD with FLG_LD=1 → C=1, Z=0 (restore wins).
- Reset mid-multiply: START MUL, then RST_N=0 at cycle 4 → BUSY=0, VALID never asserts, RESULT=0, C=Z=0. A following ADD 8'h01+8'h01 returns 8'h02 one cycle after START.
- Parameter sweep: WIDTH=16, LSR A=16'h8001 with C=1 → RESULT=16'hC000, C=1. With MUL_EN=0, SEL=16 → VALID after 1 cycle, RESULT=0, flags unchanged.
